// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers for sync_fifo_lvl (count width, parameter check).
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    function automatic int count_width(input int aw);
        return aw + 1;
    endfunction

    // True when address width and both thresholds sit inside their legal ranges.
    function automatic bit params_ok(input int aw, input int afull, input int aempty);
        bit ok;
        ok = (aw >= 1) && (aw <= 12);
        if (ok) begin
            ok = (afull >= 1) && (afull <= (1 << aw)) &&
                 (aempty >= 0) && (aempty <= (1 << aw) - 1);
        end
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : DATA_WIDTH x 2**ADDR_WIDTH array, synchronous write, async read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // Contents are deliberately left unreset so the array maps onto LUTRAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_lvl.sv
// ============================================================================
// Module      : sync_fifo_lvl
// Description : Single-clock show-ahead FIFO with occupancy, threshold flags,
//               flush and optional sticky errors (macro SYNC_FIFO_LVL_ERR_EN).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_wen,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ren,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH:0]   o_count,
    input  logic                  i_err_clr,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int                c_DEPTH   = 2 ** ADDR_WIDTH;
    localparam int                c_CW      = count_width(ADDR_WIDTH);
    localparam logic [c_CW-1:0]   c_FULL    = c_CW'(c_DEPTH);
    localparam logic [c_CW-1:0]   c_AFULL   = c_CW'(AFULL_THRESH);
    localparam logic [c_CW-1:0]   c_AEMPTY  = c_CW'(AEMPTY_THRESH);

    if (!params_ok(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("sync_fifo_lvl: ADDR_WIDTH or threshold parameters out of range");
    end

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [c_CW-1:0]       r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_rd;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // Acceptance is judged on current flags only, so no empty-bypass exists.
    assign w_wr = i_wen & ~w_full  & ~i_flush;
    assign w_rd = i_ren & ~w_empty & ~i_flush;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + ADDR_WIDTH'(1);
            if (w_rd) r_rptr <= r_rptr + ADDR_WIDTH'(1);
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (i_data),
        .i_raddr (r_rptr),
        .o_rdata (o_data)
    );

    assign o_empty        = w_empty;
    assign o_full         = w_full;
    assign o_almost_empty = (r_count <= c_AEMPTY);
    assign o_almost_full  = (r_count >= c_AFULL);
    assign o_count        = r_count;

`ifdef SYNC_FIFO_LVL_ERR_EN
    logic r_ovf;
    logic r_udf;

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (i_wen & w_full  & ~i_flush) | (r_ovf & ~i_err_clr);
            r_udf <= (i_ren & w_empty & ~i_flush) | (r_udf & ~i_err_clr);
        end
    end

    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = i_err_clr;
    assign o_ovf = 1'b0;
    assign o_udf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
// ============================================================================
// Module      : tb_sync_fifo_lvl
// Description : Directed self-checking bench for sync_fifo_lvl (DEPTH=4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_lvl;

    localparam int DW = 32;
    localparam int AW = 2;
`ifdef SYNC_FIFO_LVL_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n, i_flush, i_wen, i_ren, i_err_clr;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_data;
    logic          o_empty, o_full, o_almost_empty, o_almost_full, o_ovf, o_udf;
    logic [AW:0]   o_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_lvl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_flush        (i_flush),
        .i_wen          (i_wen),
        .i_data         (i_data),
        .i_ren          (i_ren),
        .o_data         (o_data),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_almost_empty (o_almost_empty),
        .o_almost_full  (o_almost_full),
        .o_count        (o_count),
        .i_err_clr      (i_err_clr),
        .o_ovf          (o_ovf),
        .o_udf          (o_udf)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lvl(input string tag, input int cnt);
        chk({tag, "_count"},  DW'(o_count), DW'(cnt));
        chk({tag, "_empty"},  DW'(o_empty), DW'(cnt == 0));
        chk({tag, "_full"},   DW'(o_full),  DW'(cnt == 4));
        chk({tag, "_aempty"}, DW'(o_almost_empty), DW'(cnt <= 1));
        chk({tag, "_afull"},  DW'(o_almost_full),  DW'(cnt >= 2));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_lvl(tag, 0);
        chk({tag, "_ovf"}, DW'(o_ovf), '0);
        chk({tag, "_udf"}, DW'(o_udf), '0);
    endtask

    logic [DW-1:0] stream [12];

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_wen = 1'b0; i_ren = 1'b0;
        i_err_clr = 1'b0; i_data = '0;
        #2;
        chk_reset_outputs("rst");
        step();
        step();
        i_rst_n = 1'b1;

        // Fill 0x11..0x44; head stays 0x11
        for (int k = 1; k <= 4; k++) begin
            i_wen = 1'b1; i_data = DW'(k * 32'h11);
            step();
            chk_lvl($sformatf("fill%0d", k), k);
            chk($sformatf("fill%0d_head", k), o_data, 32'h11);
        end
        i_wen = 1'b0;

        // Drain in order
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d_data", k), o_data, DW'(k * 32'h11));
            i_ren = 1'b1;
            step();
            chk_lvl($sformatf("drain%0d", k), 4 - k);
        end
        i_ren = 1'b0;

        // Streaming at count 2 across pointer wrap
        stream[0] = 32'hA0; stream[1] = 32'hA1;
        for (int i = 0; i < 10; i++) stream[i + 2] = 32'hB0 + DW'(i);
        i_wen = 1'b1;
        i_data = 32'hA0; step();
        i_data = 32'hA1; step();
        chk_lvl("pre_stream", 2);
        i_ren = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stream%0d_data", i), o_data, stream[i]);
            i_data = stream[i + 2];
            step();
            chk($sformatf("stream%0d_count", i), DW'(o_count), 32'd2);
        end
        i_wen = 1'b0;
        for (int i = 10; i < 12; i++) begin
            chk($sformatf("stream_tail%0d", i), o_data, stream[i]);
            step();
        end
        i_ren = 1'b0;
        chk_lvl("stream_end", 0);

        // Full with both requests: read only, new word dropped
        i_wen = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_data = 32'hC0 + DW'(k);
            step();
        end
        chk_lvl("full", 4);
        i_ren = 1'b1; i_data = 32'hDD;
        step();
        i_wen = 1'b0; i_ren = 1'b0;
        chk_lvl("full_both", 3);
        chk("full_both_head", o_data, 32'hC1);
        chk("ovf_set", DW'(o_ovf), DW'(ERR));
        step();
        chk("ovf_sticky", DW'(o_ovf), DW'(ERR));
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        chk("ovf_clr", DW'(o_ovf), '0);
        i_ren = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("full_drain%0d", k), o_data, 32'hC0 + DW'(k));
            step();
        end
        i_ren = 1'b0;
        chk_lvl("full_drained", 0);

        // Empty with both requests: write only, no bypass
        i_wen = 1'b1; i_ren = 1'b1; i_data = 32'hE5;
        step();
        i_wen = 1'b0; i_ren = 1'b0;
        chk_lvl("empty_both", 1);
        chk("empty_both_data", o_data, 32'hE5);
        chk("udf_both", DW'(o_udf), DW'(ERR));
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        chk("udf_clr", DW'(o_udf), '0);
        i_ren = 1'b1;
        step();
        chk_lvl("pop_last", 0);
        step();
        i_ren = 1'b0;
        chk_lvl("read_empty", 0);
        chk("udf_read_empty", DW'(o_udf), DW'(ERR));

        // Flush at count 3 with a concurrent write
        i_wen = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            i_data = 32'hF0 + DW'(k);
            step();
        end
        chk_lvl("pre_flush", 3);
        i_flush = 1'b1; i_data = 32'hF4;
        step();
        i_flush = 1'b0; i_wen = 1'b0;
        chk_lvl("flush", 0);
        chk("flush_udf_kept", DW'(o_udf), DW'(ERR));
        chk("flush_ovf", DW'(o_ovf), '0);
        step();
        chk_lvl("flush_hold", 0);

        // Asynchronous reset mid-cycle at count 3
        i_wen = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            i_data = 32'h70 + DW'(k);
            step();
        end
        i_wen = 1'b0;
        chk_lvl("pre_arst", 3);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        step();
        i_rst_n = 1'b1;
        step();
        chk_lvl("post_arst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_fifo_lvl.md
# sync_fifo_lvl

Single-clock, parametrised FIFO with show-ahead read data, occupancy count, programmable almost-full/almost-empty thresholds and synchronous flush. It replaces ad-hoc same-clock buffering between pipeline stages and the memory-side request/response paths. It is used wherever producer and consumer share one clock, so no gray-code pointer synchronisation is needed.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 1..12
- AFULL_THRESH, DEPTH-2, o_almost_full asserts at count >= this; legal 1..DEPTH
- AEMPTY_THRESH, 1, o_almost_empty asserts at count <= this; legal 0..DEPTH-1
- clk  input  1  single clock; all logic on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_flush  input  1  synchronous flush: empties FIFO
- i_wen  input  1  write request
- i_data  input  DATA_WIDTH  write data
- i_ren  input  1  read request (pop)
- o_data  output  DATA_WIDTH  head-of-queue word; valid while o_empty=0
- o_empty  output  1  count == 0
- o_full  output  1  count == DEPTH
- o_almost_empty  output  1  count <= AEMPTY_THRESH
- o_almost_full  output  1  count >= AFULL_THRESH
- o_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- i_err_clr  input  1  clears sticky error flags
- o_ovf  output  1  sticky overflow flag
- o_udf  output  1  sticky underflow flag

## Operation
- State: wptr, rptr (ADDR_WIDTH bits, natural wrap at DEPTH), count (ADDR_WIDTH+1 bits). Memory array is not reset.
- Write accepted = i_wen & ~o_full & ~i_flush. The word is stored at wptr, and wptr increments.
- Read accepted = i_ren & ~o_empty & ~i_flush. rptr increments.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full status and empty status are judged on the current-cycle flags:
  - Full with i_wen & i_ren: only the read is accepted, and count becomes DEPTH-1.
  - Empty with both: only the write is accepted, and count becomes 1. No same-cycle bypass.
- i_flush has priority over everything. On the next edge, wptr = rptr = count = 0. Memory contents are unchanged.
- All status outputs are decoded combinationally from the registered count.
- o_data = mem[rptr], an asynchronous read. The value is undefined while o_empty=1.
- Reset (i_rst_n=0), asynchronous and at any time including mid-burst:
  - pointers 0, count 0
  - o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_count=0, o_ovf=0, o_udf=0

## Timing
- Write-to-read latency is 1 cycle. A word written at edge N appears on o_data, with o_empty=0, after edge N.
- A pop at edge N presents the next word after edge N, which gives full-rate back-to-back streaming at 1 word/cycle.
- Flags and o_count change only after a clock edge or on asynchronous reset assertion. They have no combinational path from i_wen/i_ren.
- The pointers are exactly ADDR_WIDTH bits; wrap from DEPTH-1 to 0 needs no special handling. Occupancy is disambiguated by count alone.

## Configuration
- Macro: SYNC_FIFO_LVL_ERR_EN.
- When defined:
  - o_ovf is set on any cycle with i_wen & o_full & ~i_flush.
  - o_udf is set on any cycle with i_ren & o_empty & ~i_flush.
  - Both flags hold until i_err_clr=1 or reset.
  - If set and clear occur in the same cycle, set wins.
  - i_flush does not clear the flags.
- When undefined: o_ovf and o_udf are tied to 0, and i_err_clr is ignored. The ports remain, so the interface is identical in both builds.

## Structure
- Shared package fifo_pkg holds:
  - the count-width localparam helper (ADDR_WIDTH+1)
  - a parameter legality check function, used by an elaboration-time check on the threshold ranges
- One sub-module: fifo_ram (DATA_WIDTH x DEPTH, synchronous write, asynchronous read). It lets the array be swapped for a vendor LUTRAM later.
- Pointer, count, flag and error logic stay in sync_fifo_lvl.

## Test plan
- Reset then fill: DW=32, AW=2. Write 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles.
  - o_count goes 1,2,3,4. o_full=1 after the 4th edge. o_almost_full=1 from count 2.
  - Read all 4: data returns in order 0x11..0x44, and o_empty=1 after the last pop.
- Simultaneous read/write at count 2: o_count stays 2 for 10 cycles, and the data stream remains in order across pointer wrap (more than DEPTH total writes).
- Full plus both requests: o_count becomes 3 and the new word is dropped. With the ERR macro: o_ovf=1 and sticky, and i_err_clr pulse returns it to 0.
- Empty plus both requests: o_count becomes 1 and o_data equals the written word on the next cycle. Read with no write when empty: o_count stays 0, and o_udf=1 (macro on) or 0 (macro off).
- Flush at count 3 with i_wen=1: the next cycle shows o_count=0 and o_empty=1. The write is discarded and the error flags are unchanged.
- Assert i_rst_n=0 asynchronously mid-cycle at count 3: all outputs take their reset values immediately, before the next edge.
